chunked_add_sub: RTL and testbench

//  Parametrised multi-cycle two's-complement adder/subtractor; next generation of the 4-bit ripple adder.

---
 rtl/chunked_add_sub.sv | 106 ++++++++++
 tb/tb_chunked_add_sub.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_add_sub.sv
// Multi-cycle two's-complement adder/subtractor, one CHUNK-bit ripple slice per clock, LSB first.
// Optional macro ADDSUB_SAT_EN clamps the result to the signed range on overflow.
module chunked_add_sub #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             ovf
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, sum_q, sum_next, s_fin;
   logic             carry_q;
   logic [IW-1:0]    idx_q;
   logic [CHUNK-1:0] a_sl, b_sl, sl;
   logic             cy, c_msb, last, accept;

   // Operands shift right each cycle so the active slice is always the low CHUNK bits;
   // the working sum fills from the top and is complete after the last slice.
   always_comb begin
      a_sl     = a_q[CHUNK-1:0];
      b_sl     = b_q[CHUNK-1:0];
      {cy, sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
      c_msb    = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ sl[CHUNK-1];
      sum_next = (sum_q >> CHUNK) | (WIDTH'(sl) << (WIDTH - CHUNK));
      last     = (idx_q == IW'(NCH - 1));
      accept   = start && (state_q != RUN);
   end

`ifdef ADDSUB_SAT_EN
   always_comb begin
      s_fin = sum_next;
      if (c_msb ^ cy)
         s_fin = a_sl[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   end
`else
   always_comb s_fin = sum_next;
`endif

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: if (start) state_d = RUN;
         RUN: begin
            busy = 1'b1;
            if (last) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = start ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         s       <= '0;
         c_out   <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            idx_q   <= '0;
            sum_q   <= '0;
         end else if (state_q == RUN) begin
            a_q     <= a_q >> CHUNK;
            b_q     <= b_q >> CHUNK;
            carry_q <= cy;
            idx_q   <= idx_q + IW'(1);
            sum_q   <= sum_next;
            if (last) begin
               s     <= s_fin;
               c_out <= cy;
               ovf   <= c_msb ^ cy;
            end
         end
      end
   end

endmodule

// File: tb/tb_chunked_add_sub.sv
// Scoreboard bench for chunked_add_sub (WIDTH=16 with CHUNK=4, plus a CHUNK=16 instance).
module tb_chunked_add_sub;

   typedef struct {
      logic [15:0] s;
      logic        c;
      logic        v;
   } exp_t;

   logic        clk, rst, start, sub;
   logic [15:0] a, b, s;
   logic        busy, done, c_out, ovf;

   logic        start1, sub1;
   logic [15:0] a1, b1, s1;
   logic        busy1, done1, c1, v1;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   chunked_add_sub #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
      .busy(busy), .done(done), .s(s), .c_out(c_out), .ovf(ovf)
   );

   chunked_add_sub #(.WIDTH(16), .CHUNK(16)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .s(s1), .c_out(c1), .ovf(v1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic sb);
      exp_t        m;
      logic [15:0] yb;
      logic [16:0] f;
      yb  = sb ? ~y : y;
      f   = {1'b0, x} + {1'b0, yb} + {16'd0, sb};
      m.s = f[15:0];
      m.c = f[16];
      m.v = (x[15] ^ yb[15] ^ f[15]) ^ f[16];
`ifdef ADDSUB_SAT_EN
      if (m.v) m.s = x[15] ? 16'h8000 : 16'h7FFF;
`endif
      return m;
   endfunction

   task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic sb);
      start = 1'b1; a = x; b = y; sub = sb;
      @(negedge clk);
      start = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
   endtask

   task automatic wait_done(output int n, output int nb);
      n = 0; nb = 0;
      while (done !== 1'b1 && n < 20) begin
         if (busy === 1'b1) nb++;
         @(negedge clk);
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
      end
   endtask

   task automatic check_result(input string name);
      exp_t e;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty, got s=%h", name, s);
      end else begin
         e = q.pop_front();
         if ({s, c_out, ovf} !== {e.s, e.c, e.v}) begin
            errors++;
            $display("FAIL %s: got s=%h c_out=%b ovf=%b, required s=%h c_out=%b ovf=%b",
                     name, s, c_out, ovf, e.s, e.c, e.v);
         end
      end
   endtask

   task automatic expect_no_done(input string name);
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL %s: got %0d spurious done cycles, required 0", name, seen);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, s, c_out, ovf} !== 20'd0) begin
         errors++;
         $display("FAIL reset_state: got busy=%b done=%b s=%h c_out=%b ovf=%b, required all 0",
                  busy, done, s, c_out, ovf);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_vectors;
      logic [15:0] va[4] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000};
      logic [15:0] vb[4] = '{16'h0FED, 16'h0001, 16'h0001, 16'h0001};
      logic        vs[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
`ifdef ADDSUB_SAT_EN
      exp_t ve[4] = '{'{16'h2221, 1'b0, 1'b0}, '{16'h0000, 1'b1, 1'b0},
                      '{16'h7FFF, 1'b0, 1'b1}, '{16'h8000, 1'b1, 1'b1}};
`else
      exp_t ve[4] = '{'{16'h2221, 1'b0, 1'b0}, '{16'h0000, 1'b1, 1'b0},
                      '{16'h8000, 1'b0, 1'b1}, '{16'h7FFF, 1'b1, 1'b1}};
`endif
      logic [15:0] x, y;
      logic        sb;
      int          n, nb;
      for (int unsigned i = 0; i < 10; i++) begin
         if (i < 4) begin
            x = va[i]; y = vb[i]; sb = vs[i];
            q.push_back(ve[i]);
         end else begin
            x = 16'($urandom); y = 16'($urandom); sb = 1'($urandom);
            q.push_back(model(x, y, sb));
         end
         start_op(x, y, sb);
         wait_done(n, nb);
         checks++;
         if (n != 4 || nb != 4) begin
            errors++;
            $display("FAIL latency_%0d: got done after %0d cycles busy %0d, required 4 and 4", i, n, nb);
         end
         check_result($sformatf("result_%0d", i));
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pulse_%0d: got done=%b busy=%b, required 0 0", i, done, busy);
         end
      end
   endtask

   task automatic test_ignore_start;
      int n, nb;
      q.push_back(model(16'h1111, 16'h2222, 1'b0));
      start_op(16'h1111, 16'h2222, 1'b0);
      @(negedge clk);
      start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(n, nb);
      checks++;
      if (n != 2) begin
         errors++;
         $display("FAIL ignore_latency: got %0d remaining cycles, required 2", n);
      end
      check_result("ignore_result");
      expect_no_done("ignore_extra_done");
   endtask

   task automatic test_reset_midop;
      start_op(16'h4321, 16'h1111, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, s, c_out, ovf} !== 20'd0) begin
         errors++;
         $display("FAIL midop_reset: got busy=%b done=%b s=%h c_out=%b ovf=%b, required all 0",
                  busy, done, s, c_out, ovf);
      end
      @(negedge clk);
      rst = 1'b0;
      expect_no_done("midop_no_done");
   endtask

   task automatic test_back_to_back;
      int   n, nb;
      exp_t e1;
      e1 = model(16'hA5A5, 16'h5A5B, 1'b1);
      q.push_back(e1);
      start_op(16'hA5A5, 16'h5A5B, 1'b1);
      wait_done(n, nb);
      check_result("b2b_first");
      q.push_back(model(16'h7000, 16'h7000, 1'b0));
      start_op(16'h7000, 16'h7000, 1'b0);
      checks++;
      if (busy !== 1'b1 || s !== e1.s) begin
         errors++;
         $display("FAIL b2b_hold: got busy=%b s=%h, required busy=1 s=%h", busy, s, e1.s);
      end
      wait_done(n, nb);
      checks++;
      if (n + 1 != 5) begin
         errors++;
         $display("FAIL b2b_spacing: got %0d cycles between dones, required 5", n + 1);
      end
      check_result("b2b_second");
   endtask

   task automatic test_single_cycle;
      int n = 0;
      start1 = 1'b1; a1 = 16'h0003; b1 = 16'h0005; sub1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; a1 = 16'hFFFF; b1 = 16'h0; sub1 = 1'b0;
      while (done1 !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 1) begin
         errors++;
         $display("FAIL chunk16_latency: got %0d cycles, required 1", n);
      end
      checks++;
      if ({s1, c1, v1} !== {16'hFFFE, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL chunk16_result: got s=%h c_out=%b ovf=%b, required s=fffe c_out=0 ovf=0",
                  s1, c1, v1);
      end
   endtask

   initial begin
      test_reset;
      test_vectors;
      test_ignore_start;
      test_reset_midop;
      test_back_to_back;
      test_single_cycle;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
